// File: rtl/vx_dcache_req_arb.sv
// Round-robin arbiter sharing one multi-lane D$ port among NUM_REQS requesters; responses routed by tag.
// Latency: request path 0 cycles; response path 0 cycles, or 1 cycle when VX_DCACHE_ARB_RSP_BUF_EN is defined.
// Backpressure: per-lane dreq_ready goes to the granted requester only; drsp_ready follows the owner's rsp_ready_in.
module vx_dcache_req_arb #(
    parameter int NUM_REQS = 2,
    parameter int LANES    = 4,
    parameter int ADDR_W   = 30,
    parameter int TAG_IN_W = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQS*LANES-1:0]               req_valid_in,
    input  logic [NUM_REQS-1:0]                     req_rw_in,
    input  logic [NUM_REQS*LANES*ADDR_W-1:0]        req_addr_in,
    input  logic [NUM_REQS*LANES*4-1:0]             req_byteen_in,
    input  logic [NUM_REQS*LANES*32-1:0]            req_data_in,
    input  logic [NUM_REQS*TAG_IN_W-1:0]            req_tag_in,
    output logic [NUM_REQS*LANES-1:0]               req_ready_out,
    output logic [LANES-1:0]                        dreq_valid,
    output logic                                    dreq_rw,
    output logic [LANES*ADDR_W-1:0]                 dreq_addr,
    output logic [LANES*4-1:0]                      dreq_byteen,
    output logic [LANES*32-1:0]                     dreq_data,
    output logic [TAG_IN_W+$clog2(NUM_REQS)-1:0]    dreq_tag,
    input  logic [LANES-1:0]                        dreq_ready,
    input  logic [LANES-1:0]                        drsp_valid,
    input  logic [LANES*32-1:0]                     drsp_data,
    input  logic [TAG_IN_W+$clog2(NUM_REQS)-1:0]    drsp_tag,
    output logic                                    drsp_ready,
    output logic [NUM_REQS*LANES-1:0]               rsp_valid_out,
    output logic [NUM_REQS*LANES*32-1:0]            rsp_data_out,
    output logic [NUM_REQS*TAG_IN_W-1:0]            rsp_tag_out,
    input  logic [NUM_REQS-1:0]                     rsp_ready_in
);
    localparam int SEL_W     = $clog2(NUM_REQS);
    localparam int TAG_OUT_W = TAG_IN_W + SEL_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [SEL_W-1:0]    grant;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    grant_c;
    logic [SEL_W-1:0]    scan_idx;
    logic [NUM_REQS-1:0] active;
    logic                any_active;
    logic [LANES-1:0]    valid_g;
    logic                done;

    always_comb begin
        for (int r = 0; r < NUM_REQS; r++) begin
            active[r] = |req_valid_in[r*LANES +: LANES];
        end
    end

    // Descending scan so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        grant_c    = grant;
        any_active = 1'b0;
        scan_idx   = '0;
        if (state == IDLE) begin
            grant_c = '0;
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                scan_idx = rr_ptr + SEL_W'(i);
                if (active[scan_idx]) begin
                    grant_c    = scan_idx;
                    any_active = 1'b1;
                end
            end
        end
    end

    assign valid_g     = req_valid_in[grant_c*LANES +: LANES];
    assign done        = &(dreq_ready | ~valid_g);
    assign dreq_valid  = ((state == LOCKED) || any_active) ? valid_g : '0;
    assign dreq_rw     = req_rw_in[grant_c];
    assign dreq_addr   = req_addr_in[grant_c*LANES*ADDR_W +: LANES*ADDR_W];
    assign dreq_byteen = req_byteen_in[grant_c*LANES*4 +: LANES*4];
    assign dreq_data   = req_data_in[grant_c*LANES*32 +: LANES*32];
    assign dreq_tag    = {req_tag_in[grant_c*TAG_IN_W +: TAG_IN_W], grant_c};

    always_comb begin
        req_ready_out = '0;
        req_ready_out[grant_c*LANES +: LANES] = dreq_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (state == IDLE) begin
            if (any_active) begin
                if (done) begin
                    rr_ptr <= grant_c + 1'b1;
                end else begin
                    grant <= grant_c;
                    state <= LOCKED;
                end
            end
        end else if (done) begin
            rr_ptr <= grant + 1'b1;
            state  <= IDLE;
        end
    end

    // A locked requester must keep its unfired lanes up until they fire.
    locked_lanes_held: assert property (@(posedge clk) disable iff (reset) (state == LOCKED) |-> (|valid_g));

    logic [SEL_W-1:0]     rsp_sel;
    logic [LANES-1:0]     rsp_lanes;
    logic [LANES*32-1:0]  rsp_dat;
    logic [TAG_OUT_W-1:0] rsp_tag;

`ifdef VX_DCACHE_ARB_RSP_BUF_EN
    logic                 rsp_en;

    assign rsp_sel    = rsp_tag[SEL_W-1:0];
    assign rsp_en     = ~((|rsp_lanes) & ~rsp_ready_in[rsp_sel]);
    assign drsp_ready = rsp_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_lanes <= '0;
        end else if (rsp_en) begin
            rsp_lanes <= drsp_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_en) begin
            rsp_dat <= drsp_data;
            rsp_tag <= drsp_tag;
        end
    end
`else
    assign rsp_sel    = drsp_tag[SEL_W-1:0];
    assign rsp_lanes  = drsp_valid;
    assign rsp_dat    = drsp_data;
    assign rsp_tag    = drsp_tag;
    assign drsp_ready = rsp_ready_in[rsp_sel];
`endif

    always_comb begin
        rsp_valid_out = '0;
        rsp_valid_out[rsp_sel*LANES +: LANES] = rsp_lanes;
    end

    assign rsp_data_out = {NUM_REQS{rsp_dat}};
    assign rsp_tag_out  = {NUM_REQS{rsp_tag[TAG_OUT_W-1:SEL_W]}};

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Bench for vx_dcache_req_arb: directed literal checks, then random traffic against a behavioural model.
// Latency: checks taken 1 time unit after inputs change at the falling edge.
// Backpressure: random dreq_ready / rsp_ready_in; requesters drop lanes only once they have fired.
module tb_vx_dcache_req_arb;
    localparam int N = 2, L = 4, AW = 30, TW = 8, TOW = 9;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N*L-1:0]       req_valid_in;
    logic [N-1:0]         req_rw_in;
    logic [N*L*AW-1:0]    req_addr_in;
    logic [N*L*4-1:0]     req_byteen_in;
    logic [N*L*32-1:0]    req_data_in;
    logic [N*TW-1:0]      req_tag_in;
    logic [N*L-1:0]       req_ready_out;
    logic [L-1:0]         dreq_valid;
    logic                 dreq_rw;
    logic [L*AW-1:0]      dreq_addr;
    logic [L*4-1:0]       dreq_byteen;
    logic [L*32-1:0]      dreq_data;
    logic [TOW-1:0]       dreq_tag;
    logic [L-1:0]         dreq_ready;
    logic [L-1:0]         drsp_valid;
    logic [L*32-1:0]      drsp_data;
    logic [TOW-1:0]       drsp_tag;
    logic                 drsp_ready;
    logic [N*L-1:0]       rsp_valid_out;
    logic [N*L*32-1:0]    rsp_data_out;
    logic [N*TW-1:0]      rsp_tag_out;
    logic [N-1:0]         rsp_ready_in;

    vx_dcache_req_arb dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
        .req_byteen_in(req_byteen_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_out(req_ready_out),
        .dreq_valid(dreq_valid), .dreq_rw(dreq_rw), .dreq_addr(dreq_addr), .dreq_byteen(dreq_byteen),
        .dreq_data(dreq_data), .dreq_tag(dreq_tag), .dreq_ready(dreq_ready),
        .drsp_valid(drsp_valid), .drsp_data(drsp_data), .drsp_tag(drsp_tag), .drsp_ready(drsp_ready),
        .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
        .rsp_ready_in(rsp_ready_in)
    );

    always #5 clk = ~clk;

    // Requester-side transaction state
    logic [L-1:0]  pend [N];
    logic          rw   [N];
    logic [TW-1:0] tg   [N];
    logic [AW-1:0] ad   [N][L];
    logic [3:0]    be   [N][L];
    logic [31:0]   dt   [N][L];

    typedef struct {
        logic [L-1:0]    v;
        logic [L*32-1:0] d;
        logic [TOW-1:0]  t;
    } rsp_t;
    rsp_t rq [$];

    int n_vec = 0;
    int n_bad = 0;
    int owner, rr, g;
    bit any;
    logic [L-1:0]      rem;
    logic [L*AW-1:0]   ea;
    logic [L*4-1:0]    eb;
    logic [L*32-1:0]   ed;
    logic [N*L-1:0]    er;
    logic [N*L-1:0]    erv;
    logic              edr;
    rsp_t              ent;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic drive_req();
        for (int r = 0; r < N; r++) begin
            req_rw_in[r] = rw[r];
            req_tag_in[r*TW +: TW] = tg[r];
            for (int l = 0; l < L; l++) begin
                req_valid_in[r*L+l] = pend[r][l];
                req_addr_in[(r*L+l)*AW +: AW] = ad[r][l];
                req_byteen_in[(r*L+l)*4 +: 4] = be[r][l];
                req_data_in[(r*L+l)*32 +: 32] = dt[r][l];
            end
        end
    endtask

    task automatic new_req(input int r);
        pend[r] = L'($urandom_range(1, (1 << L) - 1));
        rw[r]   = 1'($urandom);
        tg[r]   = TW'($urandom);
        for (int l = 0; l < L; l++) begin
            ad[r][l] = AW'($urandom);
            be[r][l] = 4'($urandom);
            dt[r][l] = $urandom;
        end
    endtask

    initial begin
        reset = 1'b1;
        dreq_ready = '0; drsp_valid = '0; drsp_data = '0; drsp_tag = '0; rsp_ready_in = '0;
        for (int r = 0; r < N; r++) begin
            pend[r] = '0; rw[r] = 1'b0; tg[r] = '0;
            for (int l = 0; l < L; l++) begin
                ad[r][l] = AW'(32'h100 * (r + 1) + l);
                be[r][l] = 4'hF;
                dt[r][l] = 32'hC000_0000 + 32'(r * 16 + l);
            end
        end
        drive_req();
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_dreq_vld", dreq_valid, 4'h0);
        check("rst_rsp_vld", rsp_valid_out, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Single full-ready request from R0
        pend[0] = 4'hF; rw[0] = 1'b1; tg[0] = 8'h3C; dreq_ready = 4'hF;
        drive_req(); #1;
        check("t1_vld", dreq_valid, 4'hF);
        check("t1_tag", dreq_tag, 9'h078);
        check("t1_rdy", req_ready_out, 8'h0F);
        check("t1_rw", dreq_rw, 1'b1);
        check("t1_addr", dreq_addr[AW-1:0], 30'h100);

        // Both requesters always active: grants alternate starting with R1
        tg[1] = 8'hA5; pend[1] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pend[0] = 4'hF; pend[1] = 4'hF;
            drive_req(); #1;
            check("t2_grant", dreq_tag[0], (c % 2 == 0) ? 1'b1 : 1'b0);
            check("t2_rdy", req_ready_out, (c % 2 == 0) ? 8'hF0 : 8'h0F);
        end

        // Partial fire locks R0; R1 held off until release
        @(negedge clk);
        pend[0] = 4'hF; pend[1] = 4'h0; dreq_ready = 4'b0011;
        drive_req(); #1;
        check("t3_vld", dreq_valid, 4'hF);
        check("t3_rdy", req_ready_out, 8'h03);
        @(negedge clk);
        pend[0] = 4'b1100; pend[1] = 4'hF; dreq_ready = 4'b1100;
        drive_req(); #1;
        check("t3_held", req_ready_out, 8'h0C);
        check("t3_vld2", dreq_valid, 4'hC);
        check("t3_tag", dreq_tag, 9'h078);
        @(negedge clk);
        pend[0] = 4'hF; pend[1] = 4'hF; dreq_ready = 4'hF;
        drive_req(); #1;
        check("t3_next", dreq_tag[0], 1'b1);

        // Response routing by tag
        @(negedge clk);
        pend[0] = 4'h0; pend[1] = 4'h0; dreq_ready = 4'h0;
        drive_req();
        drsp_tag = 9'h0B5; drsp_valid = 4'hA; drsp_data = {4{32'hDEAD_BEEF}}; rsp_ready_in = 2'b01;
        #1;
`ifdef VX_DCACHE_ARB_RSP_BUF_EN
        check("t4_drdy_empty", drsp_ready, 1'b1);
        check("t4_rvld_empty", rsp_valid_out, 8'h00);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drsp_tag = 9'h0B4; drsp_valid = 4'h5; drsp_data = {4{32'h1234_5678}};
            #1;
            check("t6_rvld_hold", rsp_valid_out, 8'hA0);
            check("t6_rtag_hold", rsp_tag_out, 16'h5A5A);
            check("t6_rdat_hold", rsp_data_out[63:32], 32'hDEAD_BEEF);
            check("t6_drdy_hold", drsp_ready, 1'b0);
        end
        @(negedge clk);
        rsp_ready_in = 2'b10; drsp_valid = 4'h0;
        #1;
        check("t6_drdy_drain", drsp_ready, 1'b1);
        check("t6_rvld_drain", rsp_valid_out, 8'hA0);
        @(negedge clk);
        rsp_ready_in = 2'b11;
        #1;
        check("t6_no_dup", rsp_valid_out, 8'h00);
`else
        check("t4_rvld", rsp_valid_out, 8'hA0);
        check("t4_rtag", rsp_tag_out, 16'h5A5A);
        check("t4_rdat", rsp_data_out[63:32], 32'hDEAD_BEEF);
        check("t4_drdy", drsp_ready, 1'b0);
        rsp_ready_in = 2'b10;
        #1;
        check("t4_drdy1", drsp_ready, 1'b1);
`endif

        // Reset while LOCKED on R1 with rr_ptr=1
        @(negedge clk);
        drsp_valid = 4'h0;
        pend[0] = 4'hF; pend[1] = 4'h0; dreq_ready = 4'hF;
        drive_req();
        @(negedge clk);
        pend[0] = 4'h0; pend[1] = 4'hF; dreq_ready = 4'h0;
        drsp_valid = 4'h3; drsp_tag = 9'h001; rsp_ready_in = 2'b00;
        drive_req(); #1;
        check("t5_pre_tag", dreq_tag[0], 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
`ifdef VX_DCACHE_ARB_RSP_BUF_EN
        check("t5_rsp_clr", rsp_valid_out, 8'h00);
`else
        check("t5_rsp_comb", rsp_valid_out, 8'h30);
`endif
        @(negedge clk);
        reset = 1'b0;
        drsp_valid = 4'h0;
        pend[0] = 4'hF; pend[1] = 4'hF; dreq_ready = 4'hF;
        drive_req(); #1;
        check("t5_grant", dreq_tag[0], 1'b0);

        // Random phase
        @(negedge clk);
        reset = 1'b1;
        pend[0] = '0; pend[1] = '0;
        drive_req();
        @(negedge clk);
        reset = 1'b0;
        owner = -1; rr = 0; rq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (cyc == 1500) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                owner = -1; rr = 0; rq.delete();
            end
            for (int r = 0; r < N; r++)
                if (pend[r] == '0 && $urandom_range(0, 9) < 6) new_req(r);
            dreq_ready   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            drsp_valid   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            drsp_tag     = TOW'($urandom);
            drsp_data    = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready_in = N'($urandom);
            drive_req();
            #1;

            // Expected grant: current owner, else first requester with lanes from rr upward
            any = 1'b0; g = 0;
            if (owner >= 0) begin
                g = owner; any = 1'b1;
            end else begin
                for (int k = 0; k < N; k++)
                    if (!any && pend[(rr + k) % N] != '0) begin
                        g = (rr + k) % N; any = 1'b1;
                    end
            end
            if (any) begin
                for (int l = 0; l < L; l++) begin
                    ea[l*AW +: AW] = ad[g][l];
                    eb[l*4 +: 4]   = be[g][l];
                    ed[l*32 +: 32] = dt[g][l];
                end
                er = '0;
                er[g*L +: L] = dreq_ready;
                check("r_vld", dreq_valid, pend[g]);
                check("r_rdy", req_ready_out, er);
                check("r_tag", dreq_tag, {tg[g], 1'(g)});
                check("r_rw", dreq_rw, rw[g]);
                check("r_addr", dreq_addr, ea);
                check("r_be", dreq_byteen, eb);
                check("r_data", dreq_data, ed);
                rem = pend[g] & ~dreq_ready;
                pend[g] = rem;
                if (rem != '0) owner = g;
                else begin
                    owner = -1;
                    rr = (g + 1) % N;
                end
            end else begin
                check("r_idle", dreq_valid, 4'h0);
            end

`ifdef VX_DCACHE_ARB_RSP_BUF_EN
            erv = '0;
            edr = (rq.size() == 0) || rsp_ready_in[rq[0].t[0]];
            if (rq.size() != 0) begin
                erv[rq[0].t[0]*L +: L] = rq[0].v;
                check("r_rsp_tag", rsp_tag_out, {2{rq[0].t[TOW-1:1]}});
                check("r_rsp_dat", rsp_data_out, {2{rq[0].d}});
            end
            check("r_rsp_vld", rsp_valid_out, erv);
            check("r_drsp_rdy", drsp_ready, edr);
            if (rq.size() != 0 && rsp_ready_in[rq[0].t[0]]) void'(rq.pop_front());
            if (edr && drsp_valid != '0) begin
                ent.v = drsp_valid; ent.d = drsp_data; ent.t = drsp_tag;
                rq.push_back(ent);
            end
`else
            erv = '0;
            erv[drsp_tag[0]*L +: L] = drsp_valid;
            check("r_rsp_vld", rsp_valid_out, erv);
            check("r_rsp_tag", rsp_tag_out, {2{drsp_tag[TOW-1:1]}});
            check("r_rsp_dat", rsp_data_out, {2{drsp_data}});
            check("r_drsp_rdy", drsp_ready, rsp_ready_in[drsp_tag[0]]);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
